// File: rtl/uart_tx_fifo_if.sv
// Producer/UART-side bundle of the byte FIFO feeding the UART transmitter.
// master: environment (drives wr_en/wr_data and busy_tx from the UART).
// slave : the FIFO (drives status flags and the transmit/data_tx launch).
interface uart_tx_fifo_if #(
    parameter int DEPTH_LOG2 = 4
);
    logic                  wr_en;
    logic [7:0]            wr_data;
    logic                  full;
    logic                  empty;
    logic [DEPTH_LOG2:0]   count;
    logic                  overflow;
    logic                  idle;
    logic                  transmit;
    logic [7:0]            data_tx;
    logic                  busy_tx;

    modport master (
        output wr_en, wr_data, busy_tx,
        input  full, empty, count, overflow, idle, transmit, data_tx
    );

    modport slave (
        input  wr_en, wr_data, busy_tx,
        output full, empty, count, overflow, idle, transmit, data_tx
    );
endinterface

// File: rtl/uart_tx_fifo.sv
// Byte FIFO plus launch controller feeding the UART transmit/data_tx/busy_tx handshake.
// Latency: write at edge N is launched (transmit=1) at edge N+1; no same-cycle fall-through.
// Backpressure: writes while full are dropped and latch sticky overflow; launches wait for busy_tx low.
// Ports: clk, nRst (sync active-low), bus (slave): wr_en/wr_data in, full/empty/count/overflow/idle out,
//        transmit/data_tx out to the UART, busy_tx in from the UART.
module uart_tx_fifo #(
    parameter int DEPTH_LOG2 = 4
) (
    input  logic          clk,
    input  logic          nRst,
    uart_tx_fifo_if.slave bus
);
    localparam int DEPTH = 2 ** DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0]   DEPTH_CNT = {1'b1, {DEPTH_LOG2{1'b0}}};
    localparam logic [DEPTH_LOG2:0]   CNT_ONE   = 1;
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE   = 1;

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_LAUNCH = 2'd1;
    localparam logic [1:0] S_WAIT   = 2'd2;

    logic [7:0]            mem_q [DEPTH];
    logic [7:0]            mem_d [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
    logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
    logic [DEPTH_LOG2:0]   count_q, count_d;
    logic                  overflow_q, overflow_d;
    logic [1:0]            state_q, state_d;
    logic                  transmit_q, transmit_d;
    logic [7:0]            data_tx_q, data_tx_d;

    logic full_w, empty_w, wr_acc, pop;

    always_comb begin
        full_w     = (count_q == DEPTH_CNT);
        empty_w    = (count_q == '0);
        // Full is judged on the registered count: a pop in this cycle does not free a slot.
        wr_acc     = bus.wr_en && !full_w;
        pop        = 1'b0;

        mem_d      = mem_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        state_d    = state_q;
        transmit_d = transmit_q;
        data_tx_d  = data_tx_q;

        case (state_q)
            S_IDLE: begin
                transmit_d = 1'b0;
                if (!empty_w && !bus.busy_tx) begin
                    data_tx_d  = mem_q[rd_ptr_q];
                    transmit_d = 1'b1;
                    rd_ptr_d   = rd_ptr_q + PTR_ONE;
                    pop        = 1'b1;
                    state_d    = S_LAUNCH;
                end
            end
            S_LAUNCH: begin
                // Hold the request until the UART acknowledges by going busy.
                if (bus.busy_tx) begin
                    transmit_d = 1'b0;
                    state_d    = S_WAIT;
                end
            end
            S_WAIT: begin
                if (!bus.busy_tx) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                transmit_d = 1'b0;
                state_d    = S_IDLE;
            end
        endcase

        if (wr_acc) begin
            mem_d[wr_ptr_q] = bus.wr_data;
            wr_ptr_d        = wr_ptr_q + PTR_ONE;
        end
        if (bus.wr_en && full_w) begin
            overflow_d = 1'b1;
        end

        case ({wr_acc, pop})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
    end

    // Storage needs no reset: count/pointers define which entries are valid.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    always_ff @(posedge clk) begin
        if (!nRst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            state_q    <= S_IDLE;
            transmit_q <= 1'b0;
            data_tx_q  <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            state_q    <= state_d;
            transmit_q <= transmit_d;
            data_tx_q  <= data_tx_d;
        end
    end

    assign bus.full     = full_w;
    assign bus.empty    = empty_w;
    assign bus.count    = count_q;
    assign bus.overflow = overflow_q;
    assign bus.transmit = transmit_q;
    assign bus.data_tx  = data_tx_q;
    // Idle means every queued byte has also left the UART shift register.
    assign bus.idle     = empty_w && (state_q == S_IDLE) && !bus.busy_tx;
endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo with a behavioural UART and a byte scoreboard.
// Latency: n/a (testbench).
// Backpressure: the UART model holds busy_tx for frame_len cycles per byte; force_busy stalls it.
module tb_uart_tx_fifo;
    logic clk = 1'b0;
    logic nRst = 1'b0;

    uart_tx_fifo_if #(.DEPTH_LOG2(4)) bus ();

    uart_tx_fifo #(.DEPTH_LOG2(4)) dut (
        .clk  (clk),
        .nRst (nRst),
        .bus  (bus)
    );

    always #10 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [7:0] exp_q [$];

    logic       model_busy = 1'b0;
    int         model_cnt  = 0;
    logic [7:0] model_byte = 8'h00;
    logic       stable_err = 1'b0;
    logic       force_busy = 1'b0;
    logic       uart_en    = 1'b1;
    int         frame_len  = 20;

    assign bus.busy_tx = model_busy | force_busy;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // UART model: accepts a byte in the cycle it sees transmit, then stays busy for frame_len cycles.
    always @(negedge clk) begin
        if (model_busy) begin
            if (bus.data_tx !== model_byte) stable_err = 1'b1;
            model_cnt = model_cnt - 1;
            if (model_cnt <= 0) model_busy = 1'b0;
        end else if (uart_en && !force_busy && bus.transmit === 1'b1) begin
            model_busy = 1'b1;
            model_byte = bus.data_tx;
            model_cnt  = frame_len;
            if (exp_q.size() == 0) begin
                chk("unexpected_byte", {24'h0, bus.data_tx}, 32'hFFFF_FFFF);
            end else begin
                chk("rx_byte", {24'h0, bus.data_tx}, {24'h0, exp_q.pop_front()});
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic write_byte(input logic [7:0] b);
        bus.wr_en   = 1'b1;
        bus.wr_data = b;
        tick();
        bus.wr_en   = 1'b0;
    endtask

    task automatic wait_drain(input int max_cyc);
        int n = 0;
        while (!(bus.idle === 1'b1 && exp_q.size() == 0) && n < max_cyc) begin
            tick();
            n++;
        end
        chk("drain_in_time", 32'(n < max_cyc), 32'd1);
    endtask

    task automatic do_reset;
        nRst = 1'b0;
        repeat (3) tick();
        nRst = 1'b1;
    endtask

    initial begin
        // 1: reset with a write strobe asserted stores nothing
        bus.wr_en   = 1'b1;
        bus.wr_data = 8'hFF;
        repeat (3) tick();
        chk("rst_count", 32'(bus.count), 32'd0);
        chk("rst_empty", 32'(bus.empty), 32'd1);
        chk("rst_full", 32'(bus.full), 32'd0);
        chk("rst_overflow", 32'(bus.overflow), 32'd0);
        chk("rst_transmit", 32'(bus.transmit), 32'd0);
        chk("rst_data_tx", 32'(bus.data_tx), 32'd0);
        chk("rst_idle", 32'(bus.idle), 32'd1);
        bus.wr_en = 1'b0;
        nRst      = 1'b1;
        repeat (3) tick();
        chk("post_rst_count", 32'(bus.count), 32'd0);
        chk("post_rst_transmit", 32'(bus.transmit), 32'd0);

        // 2: single byte, long UART frame
        frame_len = 4340;
        stable_err = 1'b0;
        exp_q.push_back(8'hA5);
        write_byte(8'hA5);
        chk("lat_no_fallthrough", 32'(bus.transmit), 32'd0);
        chk("lat_count", 32'(bus.count), 32'd1);
        tick();
        chk("launch_transmit", 32'(bus.transmit), 32'd1);
        chk("launch_data", 32'(bus.data_tx), 32'hA5);
        chk("launch_count", 32'(bus.count), 32'd0);
        chk("launch_idle", 32'(bus.idle), 32'd0);
        tick();
        chk("transmit_one_cycle", 32'(bus.transmit), 32'd0);
        chk("busy_seen", 32'(bus.busy_tx), 32'd1);
        chk("data_held", 32'(bus.data_tx), 32'hA5);
        wait_drain(5000);
        chk("data_stable", 32'(stable_err), 32'd0);
        chk("single_idle", 32'(bus.idle), 32'd1);
        chk("single_count", 32'(bus.count), 32'd0);
        frame_len = 20;

        // 3: fill while the UART is busy, 17th byte dropped
        force_busy = 1'b1;
        for (int i = 0; i < 16; i++) begin
            exp_q.push_back(8'(i));
            write_byte(8'(i));
        end
        chk("fill_full", 32'(bus.full), 32'd1);
        chk("fill_count", 32'(bus.count), 32'd16);
        chk("fill_no_ovf", 32'(bus.overflow), 32'd0);
        write_byte(8'h10);
        chk("ovf_set", 32'(bus.overflow), 32'd1);
        chk("ovf_count", 32'(bus.count), 32'd16);
        force_busy = 1'b0;
        wait_drain(2000);
        chk("ovf_sticky", 32'(bus.overflow), 32'd1);

        // 4: paced stream of 40 bytes wraps the pointers
        do_reset();
        for (int i = 0; i < 40; i++) begin
            exp_q.push_back(8'(8'h40 + i));
            write_byte(8'(8'h40 + i));
            repeat (24) tick();
        end
        wait_drain(2000);
        chk("stream_no_ovf", 32'(bus.overflow), 32'd0);

        // 5a: write coinciding with a pop keeps count
        force_busy = 1'b1;
        for (int i = 0; i < 3; i++) begin
            exp_q.push_back(8'(8'h30 + i));
            write_byte(8'(8'h30 + i));
        end
        chk("sim_pre_count", 32'(bus.count), 32'd3);
        exp_q.push_back(8'h33);
        force_busy  = 1'b0;
        bus.wr_en   = 1'b1;
        bus.wr_data = 8'h33;
        tick();
        bus.wr_en   = 1'b0;
        chk("sim_count_same", 32'(bus.count), 32'd3);
        chk("sim_pop_launch", 32'(bus.transmit), 32'd1);
        chk("sim_pop_data", 32'(bus.data_tx), 32'h30);
        wait_drain(1000);

        // 5b: full plus write plus pop: write dropped
        force_busy = 1'b1;
        for (int i = 0; i < 16; i++) begin
            exp_q.push_back(8'(8'h80 + i));
            write_byte(8'(8'h80 + i));
        end
        chk("full2_full", 32'(bus.full), 32'd1);
        chk("full2_no_ovf", 32'(bus.overflow), 32'd0);
        force_busy  = 1'b0;
        bus.wr_en   = 1'b1;
        bus.wr_data = 8'hEE;
        tick();
        bus.wr_en   = 1'b0;
        chk("full_pop_count", 32'(bus.count), 32'd15);
        chk("full_pop_ovf", 32'(bus.overflow), 32'd1);
        chk("full_pop_launch", 32'(bus.transmit), 32'd1);
        wait_drain(2000);

        // 6: reset while a launch is pending
        uart_en    = 1'b0;
        force_busy = 1'b1;
        for (int i = 0; i < 6; i++) write_byte(8'(8'hC0 + i));
        force_busy = 1'b0;
        tick();
        chk("pend_transmit", 32'(bus.transmit), 32'd1);
        chk("pend_count", 32'(bus.count), 32'd5);
        tick();
        chk("pend_hold", 32'(bus.transmit), 32'd1);
        nRst = 1'b0;
        tick();
        chk("midrst_transmit", 32'(bus.transmit), 32'd0);
        chk("midrst_count", 32'(bus.count), 32'd0);
        chk("midrst_empty", 32'(bus.empty), 32'd1);
        chk("midrst_idle", 32'(bus.idle), 32'd1);
        nRst       = 1'b1;
        force_busy = 1'b1;
        uart_en    = 1'b1;
        exp_q.push_back(8'h5A);
        write_byte(8'h5A);
        chk("postrst_count", 32'(bus.count), 32'd1);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("postrst_wait_busy", 32'(bus.transmit), 32'd0);
        end
        force_busy = 1'b0;
        tick();
        chk("postrst_launch", 32'(bus.transmit), 32'd1);
        chk("postrst_data", 32'(bus.data_tx), 32'h5A);
        wait_drain(1000);
        chk("sb_empty", 32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
